pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register. Successor to the fixed-width MEM/WB latch.
- Carries a generic control field (WB/MEM/EX bits) and a data payload through DEPTH back-to-back stages.
- Adds a per-stage valid bit, bubble insertion (flush), global stall hold and a registered occupancy count.
- Instanced between IF/ID, ID/EX, EX/MEM and MEM/WB; DEPTH>1 is used for multi-cycle units.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_cell.sv | 94 +++++++++
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline register:
// depth limit, control-field bit positions, stage actions and counting helpers.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH   = 8;
    localparam int CTRL_WB_REGWRITE = 1;
    localparam int CTRL_WB_MEMTOREG = 0;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CELL_LOAD  = 2'd0,
        CELL_HOLD  = 2'd1,
        CELL_FLUSH = 2'd2
    } cell_op_e;

    function automatic logic [3:0] popcount(input logic [PIPE_MAX_DEPTH-1:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < PIPE_MAX_DEPTH; i++) begin
            cnt = cnt + {3'd0, bits[i]};
        end
        return cnt;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == STAT_MAX) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid, control and payload, updated on the falling clock edge.
// Priority is reset, then flush (bubble), then stall (hold), then load from the source.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 2,
    parameter int CLR_DATA = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              src_valid_i,
    input  logic [CTRL_W-1:0] src_ctrl_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_d_o
);

    cell_op_e          op_s;
    logic              valid_q;
    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Select this stage's action for the coming edge.
    always_comb begin
        op_s = CELL_LOAD;
        if (flush_i) begin
            op_s = CELL_FLUSH;
        end else if (stall_i) begin
            op_s = CELL_HOLD;
        end else begin
            op_s = CELL_LOAD;
        end
    end

    // Next-state fields; a bubble always carries a zero control field.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        case (op_s)
            CELL_FLUSH: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (CLR_DATA != 0) begin
                    data_d = '0;
                end else begin
                    data_d = data_q;
                end
            end
            CELL_HOLD: begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                data_d  = data_q;
            end
            CELL_LOAD: begin
                valid_d = src_valid_i;
                ctrl_d  = src_ctrl_i;
                data_d  = src_data_i;
            end
            default: begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                data_d  = data_q;
            end
        endcase
    end

    // Stage register; reset is synchronous to the falling edge.
    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign ctrl_o    = ctrl_q;
    assign data_o    = data_q;
    assign valid_d_o = valid_d;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised chain of DEPTH pipeline stages with bubble insertion, stall and occupancy.
// Define PIPE_STAGE_STAT_EN to add saturating stall/bubble statistics counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 2,
    parameter int DEPTH    = 1,
    parameter int CLR_DATA = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic [DEPTH-1:0]             flush_i,
    input  logic                         valid_i,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         valid_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]                  stall_cnt_o,
    output logic [31:0]                  bubble_cnt_o
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic              chain_valid_s [DEPTH+1];
    logic [CTRL_W-1:0] chain_ctrl_s  [DEPTH+1];
    logic [DATA_W-1:0] chain_data_s  [DEPTH+1];
    logic              valid_nxt_s   [DEPTH];
    logic [PIPE_MAX_DEPTH-1:0] occ_bits_s;
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_q;

    // Control is gated off for invalid input so a bubble can never write back.
    assign chain_valid_s[0] = valid_i;
    assign chain_ctrl_s[0]  = valid_i ? ctrl_i : '0;
    assign chain_data_s[0]  = data_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_cell #(
            .DATA_W   (DATA_W),
            .CTRL_W   (CTRL_W),
            .CLR_DATA (CLR_DATA)
        ) u_cell (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i[k]),
            .stall_i     (stall_i),
            .src_valid_i (chain_valid_s[k]),
            .src_ctrl_i  (chain_ctrl_s[k]),
            .src_data_i  (chain_data_s[k]),
            .valid_o     (chain_valid_s[k+1]),
            .ctrl_o      (chain_ctrl_s[k+1]),
            .data_o      (chain_data_s[k+1]),
            .valid_d_o   (valid_nxt_s[k])
        );
    end

    // Occupancy is counted from the next-state valid bits so it tracks the stages exactly.
    always_comb begin
        occ_bits_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_bits_s[k] = valid_nxt_s[k];
        end
        occ_d = OCC_W'(popcount(occ_bits_s));
    end

    // Occupancy register.
    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign valid_o = chain_valid_s[DEPTH];
    assign ctrl_o  = chain_ctrl_s[DEPTH];
    assign data_o  = chain_data_s[DEPTH];
    assign occ_o   = occ_q;

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // A bubble is counted when the last stage is empty after this edge.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!valid_nxt_s[DEPTH-1]) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 3 hold-data, DEPTH 3 clear-data,
// DEPTH 2) share one directed stimulus and are checked against a stage-array model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  flush;
    logic        vin;
    logic [1:0]  cin;
    logic [31:0] din;
    logic        chk_en;

    logic        a_v, b_v, c_v;
    logic [1:0]  a_c, b_c, c_c;
    logic [31:0] a_d, b_d, c_d;
    logic [1:0]  a_o, b_o, c_o;
    logic [31:0] a_sc, a_bc, b_sc, b_bc, c_sc, c_bc;

    int n_vec = 0;
    int n_mis = 0;

    // model: per instance, an array of stages (index 0 = input side)
    logic        mv [NI][8];
    logic [1:0]  mc [NI][8];
    logic [31:0] md [NI][8];
    int          mdep [NI] = '{3, 3, 2};
    int          mclr [NI] = '{0, 1, 0};
    logic [31:0] m_stall;
    logic [31:0] m_bub;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .DEPTH(3), .CLR_DATA(0)) u_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .ctrl_i(cin), .data_i(din), .valid_o(a_v), .ctrl_o(a_c), .data_o(a_d), .occ_o(a_o)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt_o(a_sc), .bubble_cnt_o(a_bc)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .DEPTH(3), .CLR_DATA(1)) u_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(vin),
        .ctrl_i(cin), .data_i(din), .valid_o(b_v), .ctrl_o(b_c), .data_o(b_d), .occ_o(b_o)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt_o(b_sc), .bubble_cnt_o(b_bc)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .DEPTH(2), .CLR_DATA(0)) u_c (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush[1:0]), .valid_i(vin),
        .ctrl_i(cin), .data_i(din), .valid_o(c_v), .ctrl_o(c_c), .data_o(c_d), .occ_o(c_o)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt_o(c_sc), .bubble_cnt_o(c_bc)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int m_occ(input int i);
        int n;
        n = 0;
        for (int k = 0; k < mdep[i]; k++) n += (mv[i][k] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // Model update at the falling edge: walk from the output end so each stage sees old data.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int k = mdep[i] - 1; k >= 0; k--) begin
                if (rst !== 1'b1) begin
                    mv[i][k] = 1'b0; mc[i][k] = 2'd0; md[i][k] = 32'd0;
                end else if (flush[k]) begin
                    mv[i][k] = 1'b0; mc[i][k] = 2'd0;
                    if (mclr[i] != 0) md[i][k] = 32'd0;
                end else if (!stall) begin
                    if (k == 0) begin
                        mv[i][0] = vin; mc[i][0] = vin ? cin : 2'd0; md[i][0] = din;
                    end else begin
                        mv[i][k] = mv[i][k-1]; mc[i][k] = mc[i][k-1]; md[i][k] = md[i][k-1];
                    end
                end
            end
        end
        if (rst !== 1'b1) begin
            m_stall = 32'd0; m_bub = 32'd0;
        end else begin
            if (stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (!mv[0][2] && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
        end
    end

    task automatic cmp_inst(input int i, input logic v, input logic [1:0] c,
                            input logic [31:0] d, input logic [1:0] o);
        int l;
        l = mdep[i] - 1;
        chk($sformatf("inst%0d valid_o", i), {31'd0, v}, {31'd0, mv[i][l]});
        chk($sformatf("inst%0d ctrl_o", i),  {30'd0, c}, {30'd0, mc[i][l]});
        chk($sformatf("inst%0d data_o", i),  d, md[i][l]);
        chk($sformatf("inst%0d occ_o", i),   {30'd0, o}, 32'(m_occ(i)));
        chk($sformatf("inst%0d regwrite_gated", i),
            {31'd0, (!v && c[CTRL_WB_REGWRITE])}, 32'd0);
    endtask

    // Compare process, on the inactive (rising) edge.
    always @(posedge clk) begin
        if (chk_en) begin
            cmp_inst(0, a_v, a_c, a_d, a_o);
            cmp_inst(1, b_v, b_c, b_d, b_o);
            cmp_inst(2, c_v, c_c, c_d, c_o);
`ifdef PIPE_STAGE_STAT_EN
            chk("stall_cnt", a_sc, m_stall);
            chk("bubble_cnt", a_bc, m_bub);
`endif
        end
    end

    task automatic step(input logic r, input logic s, input logic [2:0] f,
                        input logic v, input logic [1:0] c, input logic [31:0] d);
        @(posedge clk);
        rst = r; stall = s; flush = f; vin = v; cin = c; din = d;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 3'd0; vin = 1'b0; cin = 2'd0; din = 32'd0;
        chk_en = 1'b0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 8; k++) begin
                mv[i][k] = 1'b0; mc[i][k] = 2'd0; md[i][k] = 32'd0;
            end
        m_stall = 32'd0; m_bub = 32'd0;

        // reset with live inputs
        step(1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 32'hDEAD_BEEF);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 32'hDEAD_BEEF);
        chk("rst valid_o", {31'd0, a_v}, 32'd0);
        chk("rst ctrl_o",  {30'd0, a_c}, 32'd0);
        chk("rst data_o",  a_d, 32'd0);
        chk("rst occ_o",   {30'd0, a_o}, 32'd0);

        // flow
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'h11);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd2, 32'h22);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd3, 32'h33);
        chk("flow data_o", a_d, 32'h11);
        chk("flow occ_o", {30'd0, a_o}, 32'd3);
        chk("flow d2 data_o", c_d, 32'h22);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'b11, 32'h44);
        chk("flow data_o 2nd", a_d, 32'h22);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'b11, 32'h55);
        chk("flow data_o 3rd", a_d, 32'h33);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'b11, 32'h66);
        chk("bubble ctrl_o", {30'd0, a_c}, 32'd0);
        chk("bubble valid_o", {31'd0, a_v}, 32'd0);
        chk("bubble data_o", a_d, 32'h44);

        // stall on the DEPTH=2 instance
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd2, 32'hA5);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 3'b000, 1'b1, 2'b11, 32'h77);
        chk("stall d2 data_o", c_d, 32'h66);
        chk("stall d2 occ_o", {30'd0, c_o}, 32'd1);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0);
        chk("unstall d2 data_o", c_d, 32'hA5);
        chk("unstall d2 valid_o", {31'd0, c_v}, 32'd1);

        // fill DEPTH=3, then stall + flush the middle stage
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'h81);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'h82);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'h83);
        chk("full occ_o", {30'd0, a_o}, 32'd3);
        step(1'b1, 1'b1, 3'b010, 1'b1, 2'b11, 32'h99);
        chk("stflush occ_o", {30'd0, a_o}, 32'd2);
        chk("stflush data_o", a_d, 32'h81);
        chk("stflush clr occ_o", {30'd0, b_o}, 32'd2);
`ifdef PIPE_STAGE_STAT_EN
        chk("stall_cnt five", a_sc, 32'd5);
`endif
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0);
        chk("bubble out hold data_o", a_d, 32'h82);
        chk("bubble out clr data_o", b_d, 32'h0);
        chk("bubble out valid_o", {31'd0, a_v}, 32'd0);

        // flush without stall, and flush of an existing bubble
        step(1'b1, 1'b0, 3'b001, 1'b1, 2'd1, 32'hC0);
        step(1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 32'hC1);
        step(1'b1, 1'b0, 3'b100, 1'b1, 2'd2, 32'hC2);

        // reset mid-stream, then first valid after release
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'hD1);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'hD2);
        step(1'b0, 1'b0, 3'b000, 1'b1, 2'd3, 32'hD3);
        chk("midrst occ_o", {30'd0, a_o}, 32'd0);
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'hE1);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0);
        chk("midrst early valid_o", {31'd0, a_v}, 32'd0);
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0);
        chk("midrst data_o", a_d, 32'hE1);
        chk("midrst valid_o", {31'd0, a_v}, 32'd1);

        // mixed tail
        for (int n = 0; n < 40; n++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
